// File: rtl/fifo_row_reader.sv
// fifo_row_reader
// Drains a syn_fifo read port (rd_en/empty, registered data_out one cycle
// after rd_en) and packs ROW_LEN consecutive words into one row vector that
// is offered on a valid/ready stream to one row of the systolic skew logic.
//
// Optional feature macro: FIFO_ROW_READER_PAD_EN
//   defined   -> a flush emits the partial row, unfilled lanes read as zero
//   undefined -> a flush discards the partial row (default build)
module fifo_row_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_LEN    = 4,
    parameter int CNT_W      = $clog2(ROW_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          fifo_rd_en,
    input  logic                          fifo_empty,
    input  logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          flush,
    output logic [DATA_WIDTH*ROW_LEN-1:0] row_data,
    output logic [CNT_W-1:0]              row_words,
    output logic                          row_valid,
    input  logic                          row_ready
);

    localparam logic [CNT_W:0]   ROW_LEN_EXT = (CNT_W + 1)'(ROW_LEN);
    localparam logic [CNT_W-1:0] ROW_LEN_CNT = CNT_W'(ROW_LEN);

    logic [CNT_W-1:0]              fill_cnt;
    logic                          inflight;
    logic [DATA_WIDTH*ROW_LEN-1:0] row_reg;

    logic [CNT_W:0]                pending;
    logic                          room;
    logic [CNT_W-1:0]              fill_next;
    logic                          row_complete;
    logic [DATA_WIDTH*ROW_LEN-1:0] row_cap;

    // Words already captured plus the one on its way must stay below a full
    // row, so the FIFO is never asked for more words than the row can take.
    always_comb begin
        pending      = {1'b0, fill_cnt} + {{CNT_W{1'b0}}, inflight};
        room         = (pending < ROW_LEN_EXT);
        fill_next    = fill_cnt + {{(CNT_W-1){1'b0}}, inflight};
        row_complete = inflight && (fill_next == ROW_LEN_CNT);
    end

    // Pop request; forced low while reset is held so the FIFO is never
    // popped during reset regardless of the order the two resets release.
    assign fifo_rd_en = reset && !fifo_empty && !row_valid && !flush && room;

    // Row image with the arriving word (if any) dropped into lane fill_cnt.
    always_comb begin
        row_cap = row_reg;
        for (int k = 0; k < ROW_LEN; k++) begin
            if (inflight && (fill_cnt == CNT_W'(k))) begin
                row_cap[k*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
            end
        end
    end

    assign row_data = row_reg;

    // Row assembly, flush handling and the output handshake register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_cnt  <= '0;
            inflight  <= 1'b0;
            row_reg   <= '0;
            row_valid <= 1'b0;
            row_words <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (row_valid) begin
                if (row_ready) begin
                    row_valid <= 1'b0;
                    row_words <= '0;
                    fill_cnt  <= '0;
                    row_reg   <= '0;
                end
            end else if (flush) begin
`ifdef FIFO_ROW_READER_PAD_EN
                row_reg  <= row_cap;
                fill_cnt <= fill_next;
                if (fill_next != '0) begin
                    row_valid <= 1'b1;
                    row_words <= fill_next;
                end
`else
                row_reg  <= '0;
                fill_cnt <= '0;
`endif
            end else begin
                row_reg  <= row_cap;
                fill_cnt <= fill_next;
                if (row_complete) begin
                    row_valid <= 1'b1;
                    row_words <= ROW_LEN_CNT;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_row_reader.sv
// tb_fifo_row_reader
// Directed bench for fifo_row_reader (DATA_WIDTH=8, ROW_LEN=4) driving a
// behavioural syn_fifo model. Expectations follow FIFO_ROW_READER_PAD_EN.
module tb_fifo_row_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_rd_en;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        flush;
    logic [31:0] row_data;
    logic [2:0]  row_words;
    logic        row_valid;
    logic        row_ready;

    logic        wr_en;
    logic [7:0]  wr_data;

    logic [7:0]  fifo_q[$];
    int          cyc = 0;
    int          pop_cnt = 0;
    int          empty_pops = 0;
    int          pop_cyc[$];
    logic [31:0] got_rows[$];
    logic [2:0]  got_words[$];
    int          got_cyc[$];

    int          total_checks = 0;
    int          passed_checks = 0;

    fifo_row_reader #(.DATA_WIDTH(8), .ROW_LEN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_rd_en (fifo_rd_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .row_data   (row_data),
        .row_words  (row_words),
        .row_valid  (row_valid),
        .row_ready  (row_ready)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp pops and row transfers.
    always @(posedge clk) cyc <= cyc + 1;

    // syn_fifo model (registered data_out and empty) plus the row monitor.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_q.delete();
            fifo_empty <= 1'b1;
            fifo_data  <= 8'h00;
        end else begin
            if (fifo_rd_en) begin
                if (fifo_q.size() == 0) begin
                    empty_pops++;
                end else begin
                    fifo_data <= fifo_q.pop_front();
                    pop_cnt++;
                    pop_cyc.push_back(cyc);
                end
            end
            if (wr_en) fifo_q.push_back(wr_data);
            fifo_empty <= (fifo_q.size() == 0);
            if (row_valid && row_ready) begin
                got_rows.push_back(row_data);
                got_words.push_back(row_words);
                got_cyc.push_back(cyc);
            end
        end
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total_checks++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        else
            passed_checks++;
    endtask

    // Writes n bytes of words into the FIFO, least significant byte first.
    task automatic applyStimulus(input logic [31:0] words, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = words[i*8 +: 8];
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        flush = 1'b0;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitRows(input int n, input string tag);
        int b = 0;
        while (got_rows.size() < n && b < 60) begin
            @(negedge clk);
            b++;
        end
        checkOutput(tag, got_rows.size(), n);
    endtask

    task automatic waitValid(input string tag);
        int b = 0;
        while (!row_valid && b < 60) begin
            @(negedge clk);
            b++;
        end
        checkOutput(tag, row_valid, 1);
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int base_pop;
        int base_row;
        int bad_data;
        int rd_cycles;

        reset     = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        row_ready = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("reset_rd_en", fifo_rd_en, 0);
        checkOutput("reset_row_valid", row_valid, 0);
        checkOutput("reset_row_words", row_words, 0);
        checkOutput("reset_row_data", row_data, 0);
        reset = 1'b1;
        @(negedge clk);

        // Five words, consumer always ready.
        base_pop = pop_cnt;
        base_row = got_rows.size();
        applyStimulus(32'h44332211, 4);
        applyStimulus(32'h00000055, 1);
        waitRows(base_row + 1, "a_row_count");
        repeat (10) @(negedge clk);
        checkOutput("a_row_data", got_rows[base_row], 32'h44332211);
        checkOutput("a_row_words", got_words[base_row], 4);
        checkOutput("a_total_pops", pop_cnt - base_pop, 5);
        checkOutput("a_four_pops_before_xfer", pop_cyc[base_pop+3] < got_cyc[base_row], 1);
        checkOutput("a_xfer_latency", got_cyc[base_row] - pop_cyc[base_pop], 5);
        checkOutput("a_fifth_pop_after_xfer", pop_cyc[base_pop+4] - got_cyc[base_row], 1);

        // Consumer stalled for 10 cycles.
        doReset();
        row_ready = 1'b0;
        base_row  = got_rows.size();
        applyStimulus(32'h44332211, 4);
        applyStimulus(32'h00000055, 1);
        waitValid("b_row_valid");
        bad_data  = 0;
        rd_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (row_data !== 32'h44332211 || row_words !== 3'd4) bad_data++;
            if (fifo_rd_en) rd_cycles++;
            @(negedge clk);
        end
        checkOutput("b_stall_data_stable", bad_data, 0);
        checkOutput("b_stall_no_pops", rd_cycles, 0);
        checkOutput("b_fifo_level", fifo_q.size(), 1);
        row_ready = 1'b1;
        waitRows(base_row + 1, "b_row_count");
        checkOutput("b_row_data", got_rows[base_row], 32'h44332211);

        // FIFO runs dry after two words.
        doReset();
        base_row = got_rows.size();
        applyStimulus(32'h0000A2A1, 2);
        repeat (5) @(negedge clk);
        checkOutput("c_no_row_yet", got_rows.size(), base_row);
        applyStimulus(32'h0000A4A3, 2);
        waitRows(base_row + 1, "c_row_count");
        checkOutput("c_row_data", got_rows[base_row], 32'hA4A3A2A1);
        checkOutput("c_row_words", got_words[base_row], 4);

        // Flush after three captured words.
        doReset();
        base_row = got_rows.size();
        applyStimulus(32'h00030201, 3);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (8) @(negedge clk);
`ifdef FIFO_ROW_READER_PAD_EN
        checkOutput("d_pad_row_count", got_rows.size(), base_row + 1);
        checkOutput("d_pad_row_data", got_rows[base_row], 32'h00030201);
        checkOutput("d_pad_row_words", got_words[base_row], 3);
`else
        checkOutput("d_discard_no_row", got_rows.size(), base_row);
        applyStimulus(32'h07060504, 4);
        waitRows(base_row + 1, "d_next_row_count");
        checkOutput("d_next_row_data", got_rows[base_row], 32'h07060504);
        checkOutput("d_next_row_words", got_words[base_row], 4);
`endif

        // Flush in the same cycle as the second capture.
        doReset();
        base_pop = pop_cnt;
        base_row = got_rows.size();
        applyStimulus(32'h00CCBBAA, 3);
        for (int b = 0; b < 40 && pop_cnt < base_pop + 2; b++) @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("e_no_pop_on_flush", fifo_rd_en, 0);
        @(negedge clk);
        flush = 1'b0;
        repeat (6) @(negedge clk);
`ifdef FIFO_ROW_READER_PAD_EN
        checkOutput("e_pad_row_count", got_rows.size(), base_row + 1);
        checkOutput("e_pad_row_data", got_rows[base_row], 32'h0000BBAA);
        checkOutput("e_pad_row_words", got_words[base_row], 2);
`else
        checkOutput("e_discard_no_row", got_rows.size(), base_row);
        applyStimulus(32'h00FFEEDD, 3);
        waitRows(base_row + 1, "e_next_row_count");
        checkOutput("e_next_row_data", got_rows[base_row], 32'hFFEEDDCC);
`endif

        // Reset mid-row, then reset while a row is held.
        doReset();
        applyStimulus(32'h00002211, 2);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("f_mid_rd_en", fifo_rd_en, 0);
        checkOutput("f_mid_row_valid", row_valid, 0);
        checkOutput("f_mid_row_words", row_words, 0);
        checkOutput("f_mid_row_data", row_data, 0);
        @(negedge clk);
        reset     = 1'b1;
        row_ready = 1'b0;
        @(negedge clk);
        applyStimulus(32'h44332211, 4);
        waitValid("f_post_reset_valid");
        checkOutput("f_post_reset_row", row_data, 32'h44332211);
        reset = 1'b0;
        #1;
        checkOutput("f_held_row_valid", row_valid, 0);
        checkOutput("f_held_row_words", row_words, 0);
        checkOutput("f_held_row_data", row_data, 0);
        @(negedge clk);
        reset     = 1'b1;
        row_ready = 1'b1;
        @(negedge clk);
        base_row = got_rows.size();
        applyStimulus(32'hC4C3C2C1, 4);
        waitRows(base_row + 1, "f_new_row_count");
        checkOutput("f_new_row_data", got_rows[base_row], 32'hC4C3C2C1);

        checkOutput("no_pop_on_empty", empty_pops, 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
